// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter and its benches.
// Direction and mode encodings, plus the prescaler width helper.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // A counter of at least one bit is kept even when PRESCALE=1, so the port width stays legal.
   function automatic int ps_width(input int prescale);
      return (prescale <= 1) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick fires on every PRESCALE-th enabled cycle.
// Collapses to a plain wire (tick = enab) when PRESCALE=1.
module counter_prescaler #(
   parameter int PRESCALE = 1,
   parameter int PS_WIDTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic enab,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused;
         assign unused = ^{clk, rst, clr};
         assign tick   = enab;
      end else begin : g_div
         localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

         logic [PS_WIDTH-1:0] ps_cnt_reg;
         logic [PS_WIDTH-1:0] ps_cnt_next;

         assign tick = enab && (ps_cnt_reg == PS_LAST);

         // The count freezes while enab is low, so partial periods survive enable gaps.
         always_comb begin
            ps_cnt_next = ps_cnt_reg;
            if (clr) begin
               ps_cnt_next = '0;
            end else if (enab) begin
               ps_cnt_next = (ps_cnt_reg == PS_LAST) ? '0 : ps_cnt_reg + PS_WIDTH'(1);
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ps_cnt_reg <= '0;
            end else begin
               ps_cnt_reg <= ps_cnt_next;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with load, sync clear, wrap/saturate modes,
// prescaled stepping, a terminal-count pulse and a sticky overflow flag.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int MODULUS  = 2**WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclr,
   input  logic             load,
   input  logic             enab,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             ovf_clr,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] cnt_out,
   output logic             tc,
   output logic             ovf
);

   localparam int PS_WIDTH = ps_width(PRESCALE);

   // One extra bit lets MODULUS = 2**WIDTH be represented in the clamp compare.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic             tc_reg, tc_next;
   logic             ovf_reg, ovf_next;
   logic             tick;
   logic             at_top, at_bot, at_term;
   logic             term_step;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] step_val;

   counter_prescaler #(
      .PRESCALE (PRESCALE),
      .PS_WIDTH (PS_WIDTH)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (sclr | load),
      .enab (enab),
      .tick (tick)
   );

   assign at_top    = (cnt_reg == CNT_MAX);
   assign at_bot    = (cnt_reg == '0);
   assign at_term   = (up_dn == DIR_UP) ? at_top : at_bot;
   assign term_step = tick && !sclr && !load && at_term;
   assign load_val  = ({1'b0, cnt_in} >= MOD_EXT) ? CNT_MAX : cnt_in;

   always_comb begin
      step_val = cnt_reg;
      if (up_dn == DIR_UP) begin
         if (!at_top) begin
            step_val = cnt_reg + WIDTH'(1);
         end else if (sat_mode == MODE_WRAP) begin
            step_val = '0;
         end
      end else begin
         if (!at_bot) begin
            step_val = cnt_reg - WIDTH'(1);
         end else if (sat_mode == MODE_WRAP) begin
            step_val = CNT_MAX;
         end
      end
   end

   always_comb begin
      cnt_next = cnt_reg;
      if (sclr) begin
         cnt_next = '0;
      end else if (load) begin
         cnt_next = load_val;
      end else if (tick) begin
         cnt_next = step_val;
      end
   end

   // A terminal step outranks ovf_clr in the same cycle.
   always_comb begin
      tc_next  = term_step;
      ovf_next = ovf_reg;
      if (term_step) begin
         ovf_next = 1'b1;
      end else if (ovf_clr) begin
         ovf_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
         tc_reg  <= 1'b0;
         ovf_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         tc_reg  <= tc_next;
         ovf_reg <= ovf_next;
      end
   end

   assign cnt_out = cnt_reg;
   assign tc      = tc_reg;
   assign ovf     = ovf_reg;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: three counter variants share one stimulus stream and are
// checked every cycle against an arithmetic reference model.
module tb_updown_mod_counter;

   localparam int N_DUT = 3;
   localparam int MODS [N_DUT] = '{24, 24, 32};
   localparam int PRES [N_DUT] = '{1, 3, 1};

   typedef struct packed {
      logic [4:0] cnt;
      logic       tc;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclr = 1'b0, load = 1'b0, enab = 1'b0;
   logic       up_dn = 1'b1, sat_mode = 1'b0, ovf_clr = 1'b0;
   logic [4:0] cnt_in = '0;

   logic [4:0] cnt_o [N_DUT];
   logic       tc_o  [N_DUT];
   logic       ovf_o [N_DUT];

   exp_t sb [N_DUT][$];
   int   m_cnt [N_DUT];
   int   m_ps  [N_DUT];
   bit   m_ovf [N_DUT];

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(5), .MODULUS(24), .PRESCALE(1)) u_wrap24 (
      .clk(clk), .rst(rst), .sclr(sclr), .load(load), .enab(enab), .up_dn(up_dn),
      .sat_mode(sat_mode), .ovf_clr(ovf_clr), .cnt_in(cnt_in),
      .cnt_out(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

   updown_mod_counter #(.WIDTH(5), .MODULUS(24), .PRESCALE(3)) u_ps3 (
      .clk(clk), .rst(rst), .sclr(sclr), .load(load), .enab(enab), .up_dn(up_dn),
      .sat_mode(sat_mode), .ovf_clr(ovf_clr), .cnt_in(cnt_in),
      .cnt_out(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

   updown_mod_counter #(.WIDTH(5), .MODULUS(32), .PRESCALE(1)) u_full32 (
      .clk(clk), .rst(rst), .sclr(sclr), .load(load), .enab(enab), .up_dn(up_dn),
      .sat_mode(sat_mode), .ovf_clr(ovf_clr), .cnt_in(cnt_in),
      .cnt_out(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

   // Reference model: on each edge apply the counter rules and queue the expected outputs.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         for (int i = 0; i < N_DUT; i++) begin
            if (!rst) begin
               m_cnt[i] = 0;
               m_ps[i]  = 0;
               m_ovf[i] = 1'b0;
               sb[i].delete();
               sb[i].push_back('{cnt: 5'd0, tc: 1'b0, ovf: 1'b0});
            end else begin
               bit term;
               term = 1'b0;
               if (sclr) begin
                  m_cnt[i] = 0;
                  m_ps[i]  = 0;
               end else if (load) begin
                  m_cnt[i] = (int'(cnt_in) >= MODS[i]) ? MODS[i] - 1 : int'(cnt_in);
                  m_ps[i]  = 0;
               end else if (enab) begin
                  if (m_ps[i] == PRES[i] - 1) begin
                     m_ps[i] = 0;
                     if (up_dn) begin
                        if (m_cnt[i] == MODS[i] - 1) begin
                           term = 1'b1;
                           if (!sat_mode) m_cnt[i] = 0;
                        end else begin
                           m_cnt[i] = m_cnt[i] + 1;
                        end
                     end else begin
                        if (m_cnt[i] == 0) begin
                           term = 1'b1;
                           if (!sat_mode) m_cnt[i] = MODS[i] - 1;
                        end else begin
                           m_cnt[i] = m_cnt[i] - 1;
                        end
                     end
                  end else begin
                     m_ps[i] = m_ps[i] + 1;
                  end
               end
               if (term) m_ovf[i] = 1'b1;
               else if (ovf_clr) m_ovf[i] = 1'b0;
               sb[i].push_back('{cnt: 5'(m_cnt[i]), tc: term, ovf: m_ovf[i]});
            end
         end
      end
   end

   // Monitor: outputs are valid every cycle; pop and compare mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (sb[0].size() > 0) begin
            txn++;
            $display("txn %0d: c24=%0d/%0b/%0b ps3=%0d/%0b/%0b c32=%0d/%0b/%0b", txn,
                     cnt_o[0], tc_o[0], ovf_o[0], cnt_o[1], tc_o[1], ovf_o[1],
                     cnt_o[2], tc_o[2], ovf_o[2]);
         end
         for (int i = 0; i < N_DUT; i++) begin
            if (sb[i].size() > 0) begin
               exp_t e;
               exp_t a;
               e = sb[i].pop_front();
               a = '{cnt: cnt_o[i], tc: tc_o[i], ovf: ovf_o[i]};
               checks++;
               if (a !== e) begin
                  failures++;
                  $display("FAIL dut%0d txn %0d: got cnt=%0d tc=%0b ovf=%0b, want cnt=%0d tc=%0b ovf=%0b",
                           i, txn, a.cnt, a.tc, a.ovf, e.cnt, e.tc, e.ovf);
               end
            end
         end
      end
   end

   // Inputs change 2 time units after the rising edge and hold for n edges.
   task automatic drive(input logic s, input logic l, input logic e, input logic u,
                        input logic m, input logic oc, input logic [4:0] ci, input int n);
      sclr = s; load = l; enab = e; up_dn = u; sat_mode = m; ovf_clr = oc; cnt_in = ci;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #1 rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;

      // Asynchronous reset in the middle of a cycle while the count is 13.
      drive(0, 1, 0, 1, 0, 0, 5'd13, 1);
      drive(0, 0, 0, 1, 0, 0, 5'd0, 1);
      rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      drive(0, 0, 1, 1, 0, 0, 5'd0, 3);

      // Up wrap through the terminal value, then clear ovf.
      drive(0, 1, 0, 1, 0, 0, 5'd22, 1);
      drive(0, 0, 1, 1, 0, 0, 5'd0, 4);
      drive(0, 0, 0, 1, 0, 1, 5'd0, 1);

      // Down saturate at zero.
      drive(0, 1, 0, 0, 1, 0, 5'd1, 1);
      drive(0, 0, 1, 0, 1, 0, 5'd0, 4);

      // Load clamp, clear priority, terminal step beats ovf_clr.
      drive(0, 1, 0, 1, 0, 0, 5'd30, 1);
      drive(1, 1, 1, 1, 0, 0, 5'd7, 1);
      drive(0, 1, 0, 1, 0, 0, 5'd23, 1);
      drive(0, 0, 1, 1, 0, 1, 5'd0, 3);

      // Prescaled stepping with an enable gap.
      drive(0, 1, 0, 1, 0, 0, 5'd5, 1);
      drive(0, 0, 1, 1, 0, 0, 5'd0, 7);
      drive(0, 1, 0, 1, 0, 0, 5'd5, 1);
      drive(0, 0, 1, 1, 0, 0, 5'd0, 2);
      drive(0, 0, 0, 1, 0, 0, 5'd0, 3);
      drive(0, 0, 1, 1, 0, 0, 5'd0, 2);

      // Full-range modulus wrap in both directions.
      drive(0, 1, 0, 1, 0, 0, 5'd31, 1);
      drive(0, 0, 1, 1, 0, 0, 5'd0, 2);
      drive(0, 1, 0, 0, 0, 0, 5'd0, 1);
      drive(0, 0, 1, 0, 0, 0, 5'd0, 2);

      // Randomized traffic with occasional mid-cycle resets.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b0;
            @(posedge clk);
            #2 rst = 1'b1;
         end
         drive($urandom_range(0, 31) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
               5'($urandom_range(0, 31)), 1);
      end

      drive(0, 0, 0, 1, 0, 0, 5'd0, 3);
      checks++;
      if (checks < 300) begin
         failures++;
         $display("FAIL scoreboard_coverage: got %0d checks, want at least 300", checks);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
